// File: rtl/div_result_writeback.sv
// div_result_writeback: buffers divider results in a small FIFO and drains
// them to memory over the valid/ready write bus, flagging job completion.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 latch job config (write_base, write_size_input,
//                         num_write); honoured only in IDLE or DONE
//   result_valid/_data    divider result push; result_ready = FIFO not full
//   write_enable/_addr/_size/_data, write_ready, finish_write
//                         memory write bus; a beat is taken when
//                         write_ready == 1
//   all_done              job complete, held until next start or reset
//   overflow              sticky: a result arrived while the FIFO was full
//   write_count           beats accepted in the current job
module div_result_writeback #(
    parameter int DATA_WID   = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_WID    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [63:0]         write_base,
    input  logic [63:0]         write_size_input,
    input  logic [63:0]         num_write,
    input  logic                result_valid,
    input  logic [DATA_WID-1:0] result_data,
    input  logic [63:0]         write_ready,
    output logic                result_ready,
    output logic                write_enable,
    output logic                finish_write,
    output logic [63:0]         write_addr,
    output logic [63:0]         write_size,
    output logic [DATA_WID-1:0] write_data,
    output logic                all_done,
    output logic                overflow,
    output logic [63:0]         write_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_WAIT_WRITE,
        S_DONE
    } state_t;

    localparam logic [PTR_WID:0]   DEPTH_C = (PTR_WID+1)'(FIFO_DEPTH);
    localparam logic [PTR_WID:0]   OCC_ONE = (PTR_WID+1)'(1);
    localparam logic [PTR_WID-1:0] PTR_ONE = PTR_WID'(1);

    state_t state_q, state_d;

    logic [DATA_WID-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_WID-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WID-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_WID:0]    occ_q, occ_d;

    logic [63:0]         addr_q, addr_d;
    logic [63:0]         size_q, size_d;
    logic [63:0]         num_q, num_d;
    logic [63:0]         cnt_q, cnt_d;
    logic [DATA_WID-1:0] data_q, data_d;
    logic                we_q, we_d;
    logic                fin_q, fin_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;

    logic        full, empty, push, pop;
    logic [63:0] cnt_inc;

    assign full    = (occ_q == DEPTH_C);
    assign empty   = (occ_q == '0);
    assign push    = result_valid && !full;
    assign pop     = (state_q == S_WAIT_WRITE) && (write_ready == 64'd1);
    assign cnt_inc = cnt_q + 64'd1;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        addr_d   = addr_q;
        size_d   = size_q;
        num_d    = num_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        we_d     = we_q;
        fin_d    = 1'b0;
        done_d   = done_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase

        unique case (state_q)
            S_IDLE, S_DONE: begin
                // Zero-length jobs raise all_done one cycle after DONE entry.
                if (state_q == S_DONE) begin
                    done_d = 1'b1;
                end
                if (start) begin
                    addr_d  = write_base;
                    size_d  = write_size_input;
                    num_d   = num_write;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = (num_write == 64'd0) ? S_DONE : S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (!empty) begin
                    data_d  = mem_q[rd_ptr_q];
                    we_d    = 1'b1;
                    state_d = S_WAIT_WRITE;
                end
            end
            S_WAIT_WRITE: begin
                if (pop) begin
                    fin_d  = 1'b1;
                    cnt_d  = cnt_inc;
                    addr_d = addr_q + size_q;
                    if (cnt_inc == num_q) begin
                        we_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (occ_q > OCC_ONE) begin
                        // Next entry is already buffered: stream it.
                        data_d = mem_q[rd_ptr_q + PTR_ONE];
                    end else begin
                        we_d    = 1'b0;
                        state_d = S_WAIT_DATA;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A dropped push flags overflow even if the same cycle pops.
        if (result_valid && full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= result_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            num_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            fin_q    <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            num_q    <= num_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            we_q     <= we_d;
            fin_q    <= fin_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result_ready = !reset && !full;
    assign write_enable = we_q;
    assign finish_write = fin_q;
    assign write_addr   = addr_q;
    assign write_size   = size_q;
    assign write_data   = data_q;
    assign all_done     = done_q;
    assign overflow     = ovf_q;
    assign write_count  = cnt_q;

endmodule

// File: tb/tb_div_result_writeback.sv
// tb_div_result_writeback: randomized scoreboard bench for
// div_result_writeback.
module tb_div_result_writeback;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [63:0] write_base = '0;
    logic [63:0] write_size_input = '0;
    logic [63:0] num_write = '0;
    logic        result_valid = 1'b0;
    logic [63:0] result_data = '0;
    logic [63:0] write_ready = '0;
    logic        result_ready;
    logic        write_enable;
    logic        finish_write;
    logic [63:0] write_addr;
    logic [63:0] write_size;
    logic [63:0] write_data;
    logic        all_done;
    logic        overflow;
    logic [63:0] write_count;

    div_result_writeback dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .write_base       (write_base),
        .write_size_input (write_size_input),
        .num_write        (num_write),
        .result_valid     (result_valid),
        .result_data      (result_data),
        .write_ready      (write_ready),
        .result_ready     (result_ready),
        .write_enable     (write_enable),
        .finish_write     (finish_write),
        .write_addr       (write_addr),
        .write_size       (write_size),
        .write_data       (write_data),
        .all_done         (all_done),
        .overflow         (overflow),
        .write_count      (write_count)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] sb [$];
    logic [63:0] m_addr = '0;
    logic [63:0] m_size = '0;
    logic [63:0] m_num = '0;
    logic [63:0] m_cnt = '0;
    logic        exp_ovf = 1'b0;
    int          rdy_mode = 3;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model of the buffer: accepted if fewer than 4 entries are held.
    task automatic push(input logic [63:0] v);
        result_valid = 1'b1;
        result_data  = v;
        if (sb.size() < 4) sb.push_back(v);
        else exp_ovf = 1'b1;
        tick();
        result_valid = 1'b0;
    endtask

    task automatic start_job(input logic [63:0] b, input logic [63:0] s,
                             input logic [63:0] n);
        start            = 1'b1;
        write_base       = b;
        write_size_input = s;
        num_write        = n;
        m_addr  = b;
        m_size  = s;
        m_num   = n;
        m_cnt   = '0;
        exp_ovf = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget && all_done !== 1'b1; i++) tick();
        n_chk++;
        if (all_done !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_done: all_done=%b after %0d cycles, expected 1",
                     all_done, budget);
        end
    endtask

    task automatic wait_we(input int budget);
        int i;
        for (i = 0; i < budget && write_enable !== 1'b1; i++) tick();
        chk("we_rise", {63'd0, write_enable}, 64'd1);
    endtask

    // Bus acceptor: 0 tied ready, 1 random, 2 five stall cycles per beat,
    // 3 never ready.
    int stall = 0;
    initial begin
        int r;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: write_ready = 64'd1;
                1: begin
                    r = $urandom_range(0, 3);
                    if (r < 2) write_ready = 64'd1;
                    else if (r == 2) write_ready = 64'd0;
                    else write_ready = 64'h1_0000_0001;
                end
                2: begin
                    if (write_enable && stall < 5) begin
                        write_ready = 64'd0;
                        stall++;
                    end else if (write_enable) begin
                        write_ready = 64'd1;
                        stall = 0;
                    end else begin
                        write_ready = 64'd0;
                        stall = 0;
                    end
                end
                default: write_ready = 64'd0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted beat.
    logic        prev_acc = 1'b0;
    logic        stall_hold = 1'b0;
    logic        done_pend = 1'b0;
    logic [63:0] hold_addr = '0;
    logic [63:0] hold_data = '0;
    always @(negedge clk) begin
        logic acc;
        if (!reset) begin
            chk("finish_write", {63'd0, finish_write}, {63'd0, prev_acc});
            if (stall_hold) begin
                chk("stall_we", {63'd0, write_enable}, 64'd1);
                chk("stall_addr", write_addr, hold_addr);
                chk("stall_data", write_data, hold_data);
            end
            if (done_pend) begin
                chk("done_flag", {63'd0, all_done}, 64'd1);
                chk("done_count", write_count, m_num);
                done_pend = 1'b0;
            end
            acc = write_enable && (write_ready == 64'd1);
            if (acc) begin
                if (sb.size() == 0 || m_cnt == m_num) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_beat: got beat at %h, expected none",
                             write_addr);
                end else begin
                    chk("beat_addr", write_addr, m_addr);
                    chk("beat_data", write_data, sb[0]);
                    chk("beat_size", write_size, m_size);
                    chk("beat_count", write_count, m_cnt);
                    void'(sb.pop_front());
                    m_addr = m_addr + m_size;
                    m_cnt  = m_cnt + 64'd1;
                    if (m_cnt == m_num) done_pend = 1'b1;
                end
            end
            stall_hold = write_enable && !acc;
            hold_addr  = write_addr;
            hold_data  = write_data;
            prev_acc   = acc;
        end else begin
            prev_acc   = 1'b0;
            stall_hold = 1'b0;
            done_pend  = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] b, s, n, v;
        int pushed;

        // Reset state
        repeat (3) tick();
        chk("rst_we", {63'd0, write_enable}, 64'd0);
        chk("rst_done", {63'd0, all_done}, 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);
        chk("rst_count", write_count, 64'd0);
        chk("rst_addr", write_addr, 64'd0);
        chk("rst_rdy", {63'd0, result_ready}, 64'd0);
        reset = 1'b0;
        tick();
        chk("rel_rdy", {63'd0, result_ready}, 64'd1);

        // Basic and back-pressured jobs
        for (int t = 0; t < 2; t++) begin
            rdy_mode = (t == 0) ? 0 : 2;
            start_job(64'h1000, 64'd8, 64'd3);
            push(64'h3FF0000000000000);
            repeat (9) tick();
            push(64'h4000000000000000);
            repeat (9) tick();
            push(64'h4008000000000000);
            wait_done(200);
            tick();
            chk("job_count", write_count, 64'd3);
            chk("job_addr", write_addr, 64'h1018);
            chk("job_done", {63'd0, all_done}, 64'd1);
        end

        // Random jobs, the last one wrapping the address space
        for (int j = 0; j < 3; j++) begin
            rdy_mode = 1;
            n = 64'($urandom_range(5, 12));
            b = (j == 2) ? 64'hFFFF_FFFF_FFFF_FFF0 : {$urandom, $urandom};
            s = 64'($urandom_range(0, 64));
            start_job(b, s, n);
            pushed = 0;
            while (pushed < int'(n)) begin
                if (sb.size() < 4 && $urandom_range(0, 2) != 0) begin
                    push({$urandom, $urandom});
                    pushed++;
                end else begin
                    tick();
                end
            end
            wait_done(2000);
            tick();
            chk("rnd_count", write_count, n);
            chk("rnd_addr", write_addr, b + n * s);
        end

        // Overflow with no job running
        rdy_mode = 0;
        for (int k = 0; k < 5; k++) begin
            push(64'hA000 + 64'(k));
            if (k == 3) chk("full_rdy", {63'd0, result_ready}, 64'd0);
        end
        chk("ovf_set", {63'd0, overflow}, {63'd0, exp_ovf});
        start_job(64'h2000, 64'd8, 64'd4);
        chk("ovf_clr", {63'd0, overflow}, 64'd0);
        wait_done(200);
        tick();
        chk("ovf_left", 64'(sb.size()), 64'd0);
        chk("ovf_rdy", {63'd0, result_ready}, 64'd1);

        // Zero-length job
        start_job(64'h3000, 64'd8, 64'd0);
        chk("zero_done0", {63'd0, all_done}, 64'd0);
        tick();
        chk("zero_done1", {63'd0, all_done}, 64'd1);
        repeat (4) tick();
        chk("zero_we", {63'd0, write_enable}, 64'd0);

        // Push coincident with an accepted beat at occupancy 3
        rdy_mode = 3;
        for (int k = 0; k < 3; k++) push({$urandom, $urandom});
        start_job(64'h4000, 64'd16, 64'd4);
        wait_we(20);
        rdy_mode = 0;
        push({$urandom, $urandom});
        rdy_mode = 3;
        push({$urandom, $urandom});
        chk("sim_full", {63'd0, result_ready}, 64'd0);
        chk("sim_ovf", {63'd0, overflow}, 64'd0);
        rdy_mode = 0;
        wait_done(200);
        tick();
        chk("sim_count", write_count, 64'd4);

        // Asynchronous reset while a beat is pending
        rdy_mode = 3;
        start_job(64'h5000, 64'd8, 64'd2);
        wait_we(20);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_we", {63'd0, write_enable}, 64'd0);
        chk("arst_done", {63'd0, all_done}, 64'd0);
        chk("arst_count", write_count, 64'd0);
        chk("arst_fin", {63'd0, finish_write}, 64'd0);
        sb.delete();
        exp_ovf = 1'b0;
        repeat (2) tick();
        #2;
        reset = 1'b0;
        tick();
        chk("arst_rdy", {63'd0, result_ready}, 64'd1);
        rdy_mode = 0;
        b = {$urandom, $urandom};
        start_job(b, 64'd16, 64'd1);
        v = {$urandom, $urandom};
        push(v);
        wait_done(200);
        tick();
        chk("post_count", write_count, 64'd1);
        chk("post_addr", write_addr, b + 64'd16);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
